regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port between the in-order pipeline writeback (from MEM) and a long-latency unit (multi-cycle mult/div) whose results arrive out of band. It buffers long-latency results in a small FIFO, grants the write port each cycle, and keeps a per-register pending scoreboard. ID uses that scoreboard to stall on hazards. A starvation counter forces a pipeline hold so buffered results always drain.

Parameters:
DEPTH, 4, long-latency result FIFO entries (power of two, >= 2)
STARVE_MAX, 8, consecutive denied cycles with FIFO non-empty before a forced drain

Ports:
clk  in  1  global clock
clr  in  1  synchronous active-high reset
pipe_we  in  1  pipeline writeback enable (from MEM)
pipe_num  in  5  pipeline destination register
pipe_data  in  32  pipeline write data
lu_issue  in  1  ID issues a long-latency op this cycle
lu_issue_num  in  5  its destination register
lu_done  in  1  long-latency result valid
lu_num  in  5  result destination register
lu_data  in  32  result data
lu_ready  out  1  FIFO can accept lu_done this cycle
rd1_num  in  5  ID realtime read number 1
rd2_num  in  5  ID realtime read number 2
id_dst_num  in  5  ID destination register (WAW check)
hazard_stall  out  1  ID must stall
pipe_hold  out  1  freeze MEM/WB; pipeline write deferred
reg_write_en  out  1  to regfile write_en
reg_write_num  out  5  to regfile write_num
reg_write_data  out  32  to regfile write_data
overflow  out  1  sticky: lu_done dropped while full

Behaviour:
- Single clock domain. clr is synchronous and active-high. Clock and reset ports are named clk and clr.
- On clr: FIFO empty, scoreboard all 0, starve counter 0, pipe_hold=0, overflow=0. Resulting outputs: lu_ready=1, hazard_stall=0, reg_write_en=0.
- FIFO: DEPTH entries of {num[4:0], data[31:0]}. Uses registered read/write pointers with an extra wrap bit. full = count==DEPTH.
- lu_ready = !full. The value is computed from registered state only, with no same-cycle pop credit.
- lu_done && lu_ready pushes the entry.
- lu_done && !lu_ready drops the entry and sets overflow. overflow stays set until clr.
- The FIFO does not bypass. A push into an empty FIFO is granted no earlier than the next cycle.
- Write-port grant is combinational from the current cycle's inputs and state:
  - pipe_hold=1 and FIFO non-empty: grant FIFO head; pipe_we ignored (upstream re-presents it after the hold).
  - else pipe_we=1: grant pipeline.
  - else FIFO non-empty: grant FIFO head.
  - else no grant (reg_write_en=0, num/data 0).
- A granted FIFO head is popped at the clock edge.
- Writes to $0 are consumed but drive reg_write_en=0. A FIFO pop still occurs.
- Scoreboard sb[31:0], sb[0] always 0:
  - lu_issue with lu_issue_num!=0 sets sb[num].
  - A FIFO pop clears sb[popped num].
  - Set and clear of the same register in one cycle: set wins.
- hazard_stall = sb[rd1_num] | sb[rd2_num] | sb[id_dst_num], evaluated combinationally with index 0 masked.
- Starve counter (width clog2(STARVE_MAX+1)):
  - Increments when FIFO non-empty and the pipeline took the grant.
  - Resets to 0 when FIFO is granted or empty.
  - When it reaches STARVE_MAX, pipe_hold is registered to 1 for exactly one cycle and the counter resets.
  - During a hold cycle, if the FIFO became empty, pipe_hold is still 1 for that cycle and no write occurs.
- Full and pop in the same cycle: lu_ready is still 0, so a simultaneous lu_done is dropped.

Optional Feature:
WB_ARB_STATS_EN
- Defined: adds outputs stat_hold_cycles[31:0], stat_lu_writes[31:0], stat_hazard_cycles[31:0].
  - These count cycles with pipe_hold=1, FIFO pops with a nonzero num, and cycles with hazard_stall=1.
  - All three clear on clr and wrap modulo 2^32.
- Undefined: these ports and counters are absent. Behaviour is otherwise identical.

Test Plan:
- clr for 2 cycles, then idle -> lu_ready=1, hazard_stall=0, reg_write_en=0, overflow=0.
- lu_issue num 5; next cycle rd1_num=5 -> hazard_stall=1. lu_done num 5 data 0xDEADBEEF with pipe_we=0 -> next cycle reg_write_en=1, num 5, data 0xDEADBEEF. Cycle after -> hazard_stall=0.
- Same cycle pipe_we num 3 data 0x11 and FIFO head num 7 -> pipeline granted (num 3). Head granted the following idle cycle.
- pipe_we held 1 continuously with one FIFO entry -> after 8 denied cycles pipe_hold=1 for one cycle. In that cycle the FIFO entry is written, then the pipeline resumes.
- Push 4 entries with no grants (pipe_we=1, STARVE_MAX large) -> lu_ready=0. A 5th lu_done sets overflow=1, the entry is absent, and the 4 originals drain in FIFO order.
- lu_issue num 0 and lu_done num 0 -> sb unchanged, reg_write_en=0 on pop, hazard_stall stays 0 for rd1_num=0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. buffered long-latency results,
// with a per-register pending scoreboard and starvation hold. Optional stats: WB_ARB_STATS_EN.
module regfile_wb_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_num,
  input  logic [31:0] pipe_data,
  input  logic        lu_issue,
  input  logic [4:0]  lu_issue_num,
  input  logic        lu_done,
  input  logic [4:0]  lu_num,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  input  logic [4:0]  rd1_num,
  input  logic [4:0]  rd2_num,
  input  logic [4:0]  id_dst_num,
  output logic        hazard_stall,
  output logic        pipe_hold,
  output logic        reg_write_en,
  output logic [4:0]  reg_write_num,
  output logic [31:0] reg_write_data,
  output logic        overflow
`ifdef WB_ARB_STATS_EN
  ,
  output logic [31:0] stat_hold_cycles,
  output logic [31:0] stat_lu_writes,
  output logic [31:0] stat_hazard_cycles
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);

  // Result FIFO: pointers carry an extra wrap bit so full and empty are distinct.
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   count;
  logic [4:0]    mem_num  [DEPTH];
  logic [31:0]   mem_data [DEPTH];
  logic          empty;
  logic          full;
  logic [4:0]    head_num;
  logic [31:0]   head_data;
  logic          push;
  logic          pop;

  logic          grant_fifo;
  logic          grant_pipe;
  logic [4:0]    win_num;
  logic [31:0]   win_data;

  logic [31:0]   sb;
  logic [31:0]   sb_next;
  logic [SW-1:0] starve_cnt;

  assign count     = wr_ptr - rd_ptr;
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (count == (AW+1)'(DEPTH));
  assign head_num  = mem_num[rd_ptr[AW-1:0]];
  assign head_data = mem_data[rd_ptr[AW-1:0]];

  // Handshake: lu_ready depends only on registered state (no credit for a same-cycle pop);
  // a result is accepted exactly when lu_done && lu_ready, and lu_done while !lu_ready is lost.
  assign lu_ready = !full;
  assign push     = lu_done && !full;
  assign pop      = grant_fifo;

  always_comb begin
    grant_fifo = 1'b0;
    grant_pipe = 1'b0;
    win_num    = 5'd0;
    win_data   = 32'd0;
    if (pipe_hold) begin
      // Hold cycle: the pipeline write is deferred even if nothing is left to drain.
      grant_fifo = !empty;
    end else if (pipe_we) begin
      grant_pipe = 1'b1;
    end else begin
      grant_fifo = !empty;
    end
    if (grant_fifo) begin
      win_num  = head_num;
      win_data = head_data;
    end else if (grant_pipe) begin
      win_num  = pipe_num;
      win_data = pipe_data;
    end
  end

  assign reg_write_en   = (grant_fifo || grant_pipe) && (win_num != 5'd0);
  assign reg_write_num  = win_num;
  assign reg_write_data = win_data;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_num[wr_ptr[AW-1:0]]  <= lu_num;
      mem_data[wr_ptr[AW-1:0]] <= lu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      if (lu_done && full) overflow <= 1'b1;
    end
  end

  // Scoreboard: issue sets, pop clears, and a set wins over a clear of the same register.
  always_comb begin
    sb_next = sb;
    if (pop) sb_next[head_num] = 1'b0;
    if (lu_issue) sb_next[lu_issue_num] = 1'b1;
    sb_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (clr) sb <= '0;
    else     sb <= sb_next;
  end

  assign hazard_stall = ((rd1_num    != 5'd0) && sb[rd1_num]) ||
                        ((rd2_num    != 5'd0) && sb[rd2_num]) ||
                        ((id_dst_num != 5'd0) && sb[id_dst_num]);

  // The hold is raised on the edge where the denied count reaches STARVE_MAX.
  always_ff @(posedge clk) begin
    if (clr) begin
      starve_cnt <= '0;
      pipe_hold  <= 1'b0;
    end else if (!empty && grant_pipe) begin
      if (starve_cnt == SW'(STARVE_MAX - 1)) begin
        starve_cnt <= '0;
        pipe_hold  <= 1'b1;
      end else begin
        starve_cnt <= starve_cnt + SW'(1);
        pipe_hold  <= 1'b0;
      end
    end else begin
      starve_cnt <= '0;
      pipe_hold  <= 1'b0;
    end
  end

`ifdef WB_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (clr) begin
      stat_hold_cycles   <= 32'd0;
      stat_lu_writes     <= 32'd0;
      stat_hazard_cycles <= 32'd0;
    end else begin
      if (pipe_hold)                     stat_hold_cycles   <= stat_hold_cycles + 32'd1;
      if (pop && (head_num != 5'd0))     stat_lu_writes     <= stat_lu_writes + 32'd1;
      if (hazard_stall)                  stat_hazard_cycles <= stat_hazard_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, hazards, grant priority, starvation hold,
// FIFO overflow, register-zero handling and back-to-back pipeline writes.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        clr;
  logic        pipe_we;
  logic [4:0]  pipe_num;
  logic [31:0] pipe_data;
  logic        lu_issue;
  logic [4:0]  lu_issue_num;
  logic        lu_done;
  logic [4:0]  lu_num;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic [4:0]  rd1_num;
  logic [4:0]  rd2_num;
  logic [4:0]  id_dst_num;
  logic        hazard_stall;
  logic        pipe_hold;
  logic        reg_write_en;
  logic [4:0]  reg_write_num;
  logic [31:0] reg_write_data;
  logic        overflow;
`ifdef WB_ARB_STATS_EN
  logic [31:0] stat_hold_cycles;
  logic [31:0] stat_lu_writes;
  logic [31:0] stat_hazard_cycles;
`endif

  int n_cmp = 0;
  int n_err = 0;

  regfile_wb_arbiter #(.DEPTH(4), .STARVE_MAX(8)) dut (
    .clk(clk), .clr(clr),
    .pipe_we(pipe_we), .pipe_num(pipe_num), .pipe_data(pipe_data),
    .lu_issue(lu_issue), .lu_issue_num(lu_issue_num),
    .lu_done(lu_done), .lu_num(lu_num), .lu_data(lu_data), .lu_ready(lu_ready),
    .rd1_num(rd1_num), .rd2_num(rd2_num), .id_dst_num(id_dst_num),
    .hazard_stall(hazard_stall), .pipe_hold(pipe_hold),
    .reg_write_en(reg_write_en), .reg_write_num(reg_write_num), .reg_write_data(reg_write_data),
    .overflow(overflow)
`ifdef WB_ARB_STATS_EN
    ,
    .stat_hold_cycles(stat_hold_cycles),
    .stat_lu_writes(stat_lu_writes),
    .stat_hazard_cycles(stat_hazard_cycles)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    pipe_we = 0; pipe_num = 0; pipe_data = 0;
    lu_issue = 0; lu_issue_num = 0;
    lu_done = 0; lu_num = 0; lu_data = 0;
    rd1_num = 0; rd2_num = 0; id_dst_num = 0;
  endtask

  task automatic test_reset();
    clr = 1; drive_idle();
    tick(); tick();
    clr = 0;
    @(negedge clk);
    n_cmp++;
    if ({lu_ready, hazard_stall, reg_write_en, overflow, pipe_hold} !== 5'b10000) begin
      n_err++;
      $display("FAIL reset_status got=%b exp=10000",
               {lu_ready, hazard_stall, reg_write_en, overflow, pipe_hold});
    end
    n_cmp++;
    if ({reg_write_num, reg_write_data} !== 37'd0) begin
      n_err++;
      $display("FAIL reset_wr got=%h/%h exp=0/0", reg_write_num, reg_write_data);
    end
    tick();
  endtask

  task automatic test_hazard();
    // issue r5; stall must come from the registered scoreboard only
    drive_idle(); lu_issue = 1; lu_issue_num = 5; rd1_num = 5;
    @(negedge clk);
    n_cmp++;
    if (hazard_stall !== 1'b0) begin
      n_err++; $display("FAIL hazard_issue_cycle got=%b exp=0", hazard_stall);
    end
    tick();
    drive_idle(); rd1_num = 5; lu_done = 1; lu_num = 5; lu_data = 32'hDEADBEEF;
    @(negedge clk);
    n_cmp++;
    if ({hazard_stall, reg_write_en} !== 2'b10) begin
      n_err++; $display("FAIL hazard_set got=%b exp=10", {hazard_stall, reg_write_en});
    end
    tick();
    drive_idle(); rd1_num = 5;
    @(negedge clk);
    n_cmp++;
    if ({hazard_stall, reg_write_en, reg_write_num, reg_write_data} !== {1'b1, 1'b1, 5'd5, 32'hDEADBEEF}) begin
      n_err++;
      $display("FAIL lu_write got=%b/%b/%0d/%h exp=1/1/5/deadbeef",
               hazard_stall, reg_write_en, reg_write_num, reg_write_data);
    end
    tick();
    drive_idle(); rd1_num = 5;
    @(negedge clk);
    n_cmp++;
    if ({hazard_stall, reg_write_en} !== 2'b00) begin
      n_err++; $display("FAIL hazard_clear got=%b exp=00", {hazard_stall, reg_write_en});
    end
    tick();
  endtask

  task automatic test_waw_and_set_wins();
    drive_idle(); lu_done = 1; lu_num = 9; lu_data = 32'h99;
    tick();
    // pop of r9 and re-issue of r9 in the same cycle: set wins
    drive_idle(); lu_issue = 1; lu_issue_num = 9;
    tick();
    drive_idle(); id_dst_num = 9;
    @(negedge clk);
    n_cmp++;
    if (hazard_stall !== 1'b1) begin
      n_err++; $display("FAIL set_wins_dst got=%b exp=1", hazard_stall);
    end
    id_dst_num = 0; rd2_num = 9;
    #1;
    n_cmp++;
    if (hazard_stall !== 1'b1) begin
      n_err++; $display("FAIL hazard_rd2 got=%b exp=1", hazard_stall);
    end
    lu_done = 1; lu_num = 9; lu_data = 32'h9A;
    tick();
    drive_idle(); rd2_num = 9;
    tick();
    drive_idle(); rd2_num = 9; id_dst_num = 9;
    @(negedge clk);
    n_cmp++;
    if (hazard_stall !== 1'b0) begin
      n_err++; $display("FAIL waw_clear got=%b exp=0", hazard_stall);
    end
    tick();
  endtask

  task automatic test_priority();
    drive_idle(); lu_done = 1; lu_num = 7; lu_data = 32'h77;
    tick();
    drive_idle(); pipe_we = 1; pipe_num = 3; pipe_data = 32'h11;
    @(negedge clk);
    n_cmp++;
    if ({reg_write_en, reg_write_num, reg_write_data} !== {1'b1, 5'd3, 32'h11}) begin
      n_err++; $display("FAIL prio_pipe got=%b/%0d/%h exp=1/3/11", reg_write_en, reg_write_num, reg_write_data);
    end
    tick();
    drive_idle();
    @(negedge clk);
    n_cmp++;
    if ({reg_write_en, reg_write_num, reg_write_data} !== {1'b1, 5'd7, 32'h77}) begin
      n_err++; $display("FAIL prio_fifo got=%b/%0d/%h exp=1/7/77", reg_write_en, reg_write_num, reg_write_data);
    end
    tick();
    drive_idle();
    @(negedge clk);
    n_cmp++;
    if ({reg_write_en, reg_write_num, reg_write_data} !== 38'd0) begin
      n_err++; $display("FAIL prio_idle got=%b/%0d/%h exp=0/0/0", reg_write_en, reg_write_num, reg_write_data);
    end
    tick();
  endtask

  task automatic test_starve();
    int bad;
    bad = 0;
    // cycle 0 pushes one entry; cycles 1..8 deny it while the pipeline writes
    for (int i = 0; i <= 8; i++) begin
      drive_idle(); pipe_we = 1; pipe_num = 1; pipe_data = i;
      if (i == 0) begin lu_done = 1; lu_num = 12; lu_data = 32'hC0FFEE; end
      @(negedge clk);
      if ({pipe_hold, reg_write_en, reg_write_num} !== {1'b0, 1'b1, 5'd1}) bad++;
      tick();
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++; $display("FAIL starve_denied got=%0d bad cycles exp=0", bad);
    end
    drive_idle(); pipe_we = 1; pipe_num = 1; pipe_data = 32'h9;
    @(negedge clk);
    n_cmp++;
    if ({pipe_hold, reg_write_en, reg_write_num, reg_write_data} !== {1'b1, 1'b1, 5'd12, 32'hC0FFEE}) begin
      n_err++;
      $display("FAIL starve_hold got=%b/%b/%0d/%h exp=1/1/12/c0ffee",
               pipe_hold, reg_write_en, reg_write_num, reg_write_data);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if ({pipe_hold, reg_write_en, reg_write_num, reg_write_data} !== {1'b0, 1'b1, 5'd1, 32'h9}) begin
      n_err++;
      $display("FAIL starve_resume got=%b/%b/%0d/%h exp=0/1/1/9",
               pipe_hold, reg_write_en, reg_write_num, reg_write_data);
    end
    tick();
    drive_idle();
    tick();
  endtask

  task automatic test_overflow();
    logic [4:0]  exp_num  [4] = '{5'd20, 5'd21, 5'd22, 5'd23};
    logic [31:0] exp_data [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    int bad;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      drive_idle(); pipe_we = 1; pipe_num = 2; pipe_data = 32'hAA;
      lu_done = 1; lu_num = exp_num[i]; lu_data = exp_data[i];
      @(negedge clk);
      if ({lu_ready, reg_write_num} !== {1'b1, 5'd2}) bad++;
      tick();
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++; $display("FAIL fill_ready got=%0d bad cycles exp=0", bad);
    end
    drive_idle(); pipe_we = 1; pipe_num = 2; lu_done = 1; lu_num = 24; lu_data = 32'h55;
    @(negedge clk);
    n_cmp++;
    if ({lu_ready, overflow} !== 2'b00) begin
      n_err++; $display("FAIL full_ready got=%b exp=00", {lu_ready, overflow});
    end
    tick();
    // full while popping: lu_ready stays low and this push is lost too
    drive_idle(); lu_done = 1; lu_num = 25; lu_data = 32'h66;
    @(negedge clk);
    n_cmp++;
    if ({lu_ready, overflow} !== 2'b01) begin
      n_err++; $display("FAIL overflow_set got=%b exp=01", {lu_ready, overflow});
    end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) begin drive_idle(); @(negedge clk); end
      if ({reg_write_en, reg_write_num, reg_write_data} !== {1'b1, exp_num[i], exp_data[i]}) bad++;
      tick();
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++; $display("FAIL drain_order got=%0d bad pops exp=0", bad);
    end
    drive_idle();
    @(negedge clk);
    n_cmp++;
    if ({reg_write_en, lu_ready, overflow} !== 3'b011) begin
      n_err++; $display("FAIL drain_empty got=%b exp=011", {reg_write_en, lu_ready, overflow});
    end
    // clr with a push in flight clears everything, including overflow
    lu_done = 1; lu_num = 30; lu_data = 32'h30; lu_issue = 1; lu_issue_num = 30;
    clr = 1;
    tick();
    clr = 0; drive_idle(); rd1_num = 30;
    @(negedge clk);
    n_cmp++;
    if ({reg_write_en, lu_ready, overflow, hazard_stall} !== 4'b0100) begin
      n_err++;
      $display("FAIL clr_clears got=%b exp=0100", {reg_write_en, lu_ready, overflow, hazard_stall});
    end
    tick();
  endtask

  task automatic test_zero();
    drive_idle(); lu_issue = 1; lu_issue_num = 0; lu_done = 1; lu_num = 0; lu_data = 32'hAB;
    tick();
    drive_idle(); lu_done = 1; lu_num = 6; lu_data = 32'h66;
    @(negedge clk);
    n_cmp++;
    if ({hazard_stall, reg_write_en} !== 2'b00) begin
      n_err++; $display("FAIL zero_write got=%b exp=00", {hazard_stall, reg_write_en});
    end
    tick();
    drive_idle();
    @(negedge clk);
    n_cmp++;
    if ({reg_write_en, reg_write_num, reg_write_data} !== {1'b1, 5'd6, 32'h66}) begin
      n_err++;
      $display("FAIL zero_popped got=%b/%0d/%h exp=1/6/66", reg_write_en, reg_write_num, reg_write_data);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [4:0]  v_num  [4] = '{5'd4, 5'd0, 5'd31, 5'd17};
    logic [31:0] v_data [4] = '{32'h1234_5678, 32'hFFFF_FFFF, 32'h0BAD_F00D, 32'h0000_0001};
    logic        v_en   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      drive_idle(); pipe_we = 1; pipe_num = v_num[i]; pipe_data = v_data[i];
      @(negedge clk);
      n_cmp++;
      if ({reg_write_en, reg_write_num, reg_write_data} !== {v_en[i], v_num[i], v_data[i]}) begin
        n_err++;
        $display("FAIL b2b_%0d got=%b/%0d/%h exp=%b/%0d/%h", i, reg_write_en, reg_write_num,
                 reg_write_data, v_en[i], v_num[i], v_data[i]);
      end
      tick();
    end
    drive_idle();
    tick();
  endtask

  initial begin
    clr = 1;
    drive_idle();
    test_reset();
    test_hazard();
    test_waw_and_set_wins();
    test_priority();
    test_starve();
    test_overflow();
    test_zero();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
